// File: rtl/onehot_decoder_driver.sv
// Takes a 3-bit line index over valid/ready and drives the matching one-hot
// pattern for HOLD_CYCLES cycles, then one all-zero guard cycle.
// Optional output checker: define ONEHOT_SELFCHECK_EN.
module onehot_decoder_driver #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] in_code,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_onehot,
    output logic       out_active,
    output logic       done,
    output logic       check_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    logic [1:0] state;
    logic [7:0] cnt;

    assign in_ready = (state == ST_IDLE) && en;

    // Dropping en aborts a drive and wins over counter expiry, so no done then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= 8'd0;
            out_onehot <= 8'h00;
            out_active <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid && en) begin
                        out_onehot <= 8'b1 << in_code;
                        out_active <= 1'b1;
                        cnt        <= HOLD_LOAD;
                        state      <= ST_DRIVE;
                    end else begin
                        out_onehot <= 8'h00;
                        out_active <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    if (!en) begin
                        out_onehot <= 8'h00;
                        out_active <= 1'b0;
                        cnt        <= 8'd0;
                        state      <= ST_IDLE;
                    end else if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        out_onehot <= 8'h00;
                        out_active <= 1'b0;
                        done       <= 1'b1;
                        state      <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    out_onehot <= 8'h00;
                    out_active <= 1'b0;
                    cnt        <= 8'd0;
                    state      <= ST_IDLE;
                end
                default: begin
                    out_onehot <= 8'h00;
                    out_active <= 1'b0;
                    cnt        <= 8'd0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ONEHOT_SELFCHECK_EN
    logic multi_hot;
    logic active_mismatch;

    // x & (x-1) is non-zero exactly when more than one bit is set.
    assign multi_hot       = (out_onehot & (out_onehot - 8'd1)) != 8'h00;
    assign active_mismatch = out_active != (out_onehot != 8'h00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            check_err <= 1'b0;
        end else if (multi_hot || active_mismatch) begin
            check_err <= 1'b1;
        end
    end
`else
    assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_decoder_driver.sv
// Self-checking bench: two decoder instances (hold 4 and hold 1) share inputs and are
// compared every cycle against a timestamp-based reference model.
module tb_onehot_decoder_driver;

    localparam int HOLD0 = 4;
    localparam int HOLD1 = 1;
`ifdef ONEHOT_SELFCHECK_EN
    localparam logic CHECK_EXP = 1'b1;
`else
    localparam logic CHECK_EXP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] in_code;
    logic       in_valid;
    logic       rdy [2];
    logic [7:0] oh  [2];
    logic       act [2];
    logic       dn  [2];
    logic       ce  [2];

    int compareCount = 0;
    int failCount    = 0;

    // Reference model: each instance remembers the edge at which it accepted its code.
    int         edgeCnt = 0;
    bit         mBusy [2];
    int         mAcc  [2];
    logic [2:0] mCode [2];
    bit         mAccepted [2];
    int         mHold [2];
    int         doneCount0;

    always #5 clk = ~clk;

    onehot_decoder_driver #(.HOLD_CYCLES(HOLD0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .in_code(in_code), .in_valid(in_valid),
        .in_ready(rdy[0]), .out_onehot(oh[0]), .out_active(act[0]), .done(dn[0]),
        .check_err(ce[0])
    );

    onehot_decoder_driver #(.HOLD_CYCLES(HOLD1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .in_code(in_code), .in_valid(in_valid),
        .in_ready(rdy[1]), .out_onehot(oh[1]), .out_active(act[1]), .done(dn[1]),
        .check_err(ce[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic bit modelReady(int i);
        int age;
        age = edgeCnt - mAcc[i];
        return en && (!mBusy[i] || age >= mHold[i] + 1);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mBusy[i]     = 1'b0;
            mAcc[i]      = 0;
            mCode[i]     = 3'd0;
            mAccepted[i] = 1'b0;
        end
    endtask

    // One clock: ready checked at the falling edge, outputs checked 1 ns after the rising edge.
    task automatic stepCycle();
        int   age;
        bit   rdyExp [2];
        logic [7:0] ohExp;
        logic actExp;
        logic dnExp;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            rdyExp[i] = modelReady(i);
            checkOutput($sformatf("ready%0d", i), 32'(rdy[i]), 32'(rdyExp[i]));
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            age = edgeCnt - mAcc[i];
            mAccepted[i] = 1'b0;
            if (rdyExp[i] && in_valid) begin
                mBusy[i]     = 1'b1;
                mAcc[i]      = edgeCnt + 1;
                mCode[i]     = in_code;
                mAccepted[i] = 1'b1;
            end else if (mBusy[i] && !en && age <= mHold[i]) begin
                mBusy[i] = 1'b0;
            end
        end
        edgeCnt++;
        #1;
        for (int i = 0; i < 2; i++) begin
            ohExp  = 8'h00;
            actExp = 1'b0;
            dnExp  = 1'b0;
            if (mBusy[i]) begin
                age = edgeCnt - mAcc[i];
                if (age < mHold[i]) begin
                    ohExp  = 8'(1 << mCode[i]);
                    actExp = 1'b1;
                end else if (age == mHold[i]) begin
                    dnExp = 1'b1;
                end else begin
                    mBusy[i] = 1'b0;
                end
            end
            checkOutput($sformatf("onehot%0d", i), 32'(oh[i]), 32'(ohExp));
            checkOutput($sformatf("active%0d", i), 32'(act[i]), 32'(actExp));
            checkOutput($sformatf("done%0d", i), 32'(dn[i]), 32'(dnExp));
            checkOutput($sformatf("atMostOneHot%0d", i), 32'($countones(oh[i]) <= 1), 32'd1);
            checkOutput($sformatf("checkErr%0d", i), 32'(ce[i]), 32'd0);
        end
        if (dn[0]) doneCount0++;
    endtask

    task automatic applyStimulus(input logic e, input logic v, input logic [2:0] c);
        en       = e;
        in_valid = v;
        in_code  = c;
        stepCycle();
    endtask

    initial begin
        int codeIdx;
        int guard;
        mHold[0] = HOLD0;
        mHold[1] = HOLD1;
        modelReset();

        // Reset state
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_code = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetOnehot", 32'(oh[0]), 32'h00);
        checkOutput("resetActive", 32'(act[0]), 32'd0);
        checkOutput("resetDone", 32'(dn[0]), 32'd0);
        checkOutput("resetCheckErr", 32'(ce[0]), 32'd0);
        rst = 1'b0;

        // Idle for 20 cycles
        doneCount0 = 0;
        repeat (20) applyStimulus(1'b1, 1'b0, 3'd0);
        checkOutput("idleReady", 32'(rdy[0]), 32'd1);
        checkOutput("idleNoDone", 32'(doneCount0), 32'd0);

        // Single code 5 with hold 4
        applyStimulus(1'b1, 1'b1, 3'd5);
        checkOutput("singleHold0", 32'(oh[0]), 32'h20);
        for (int k = 1; k < HOLD0; k++) begin
            applyStimulus(1'b1, 1'b0, 3'd0);
            checkOutput($sformatf("singleHold%0d", k), 32'(oh[0]), 32'h20);
        end
        applyStimulus(1'b1, 1'b0, 3'd0);
        checkOutput("singleDone", 32'(dn[0]), 32'd1);
        checkOutput("singleCleared", 32'(oh[0]), 32'h00);
        checkOutput("singleGapReady", 32'(rdy[0]), 32'd0);
        applyStimulus(1'b1, 1'b0, 3'd0);
        checkOutput("singleReadyBack", 32'(rdy[0]), 32'd1);

        // Back-to-back sweep of all eight codes
        doneCount0 = 0;
        codeIdx = 0;
        guard = 0;
        while (codeIdx < 8 && guard < 200) begin
            applyStimulus(1'b1, 1'b1, 3'(codeIdx));
            if (mAccepted[0]) codeIdx++;
            guard++;
        end
        checkOutput("sweepAccepted", 32'(codeIdx), 32'd8);
        repeat (HOLD0 + 2) applyStimulus(1'b1, 1'b0, 3'd0);
        checkOutput("sweepDoneCount", 32'(doneCount0), 32'd8);

        // Abort during the second drive cycle of code 2
        repeat (HOLD0 + 2) applyStimulus(1'b1, 1'b0, 3'd0);
        doneCount0 = 0;
        applyStimulus(1'b1, 1'b1, 3'd2);
        checkOutput("abortAccepted", 32'(oh[0]), 32'h04);
        applyStimulus(1'b1, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b0, 3'd0);
        checkOutput("abortCleared", 32'(oh[0]), 32'h00);
        checkOutput("abortInactive", 32'(act[0]), 32'd0);
        applyStimulus(1'b1, 1'b1, 3'd3);
        checkOutput("abortReaccept", 32'(oh[0]), 32'h08);
        repeat (HOLD0 + 2) applyStimulus(1'b1, 1'b0, 3'd0);
        checkOutput("abortDoneCount", 32'(doneCount0), 32'd1);

        // Randomized traffic
        repeat (600)
            applyStimulus(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                          3'($urandom_range(0, 7)));

        // Asynchronous reset in the middle of code 7
        repeat (HOLD0 + 2) applyStimulus(1'b1, 1'b0, 3'd0);
        applyStimulus(1'b1, 1'b1, 3'd7);
        applyStimulus(1'b1, 1'b0, 3'd0);
        checkOutput("asyncPreOnehot", 32'(oh[0]), 32'h80);
        rst = 1'b1;
        #2;
        checkOutput("asyncOnehot", 32'(oh[0]), 32'h00);
        checkOutput("asyncActive", 32'(act[0]), 32'd0);
        checkOutput("asyncDone", 32'(dn[0]), 32'd0);
        #1;
        rst = 1'b0;
        modelReset();
        applyStimulus(1'b1, 1'b1, 3'd4);
        checkOutput("asyncReaccept", 32'(oh[0]), 32'h10);
        repeat (HOLD0 + 2) applyStimulus(1'b1, 1'b0, 3'd0);

        // Forced illegal pattern for the self-checker
        force dut0.out_onehot = 8'h03;
        @(posedge clk);
        #1;
        release dut0.out_onehot;
        @(posedge clk);
        #1;
        checkOutput("selfCheckSet", 32'(ce[0]), 32'(CHECK_EXP));
        @(posedge clk);
        #1;
        checkOutput("selfCheckSticky", 32'(ce[0]), 32'(CHECK_EXP));
        rst = 1'b1;
        #2;
        checkOutput("selfCheckCleared", 32'(ce[0]), 32'd0);
        #1;
        rst = 1'b0;
        modelReset();
        repeat (4) applyStimulus(1'b1, 1'b0, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
